uart_tx_queue: RTL and testbench

Byte queue and launch sequencer between the CPU's UART transmit peripheral port and the `uart` transmitter. The CPU writes bytes at full clock rate; the block buffers them in a FIFO. It feeds them one at a time to the transmitter using the transmitter's `tx_en` strobe and `tx_status` idle flag. This removes CPU software polling of `tx_status` between bytes.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_queue_if.sv | 38 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_queue.sv | 118 +++++++++++
 tb/tb_uart_tx_queue.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: launch FSM encoding and default sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } txq_state_e;

    localparam int unsigned AddrWDefault       = 4;
    localparam int unsigned BusyTimeoutDefault = 16;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU write port and transmitter handshake of the UART transmit queue.
// Carries the statistics counters when UART_TXQ_STATS_EN is defined.
interface uart_tx_queue_if #(
    parameter int unsigned ADDR_W = 4
);
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            clr_ovf;
    logic            tx_status;
    logic            tx_en;
    logic [7:0]      tx_data;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            overflow;
`ifdef UART_TXQ_STATS_EN
    logic [15:0]     sent_cnt;
    logic [15:0]     drop_cnt;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_status,
        input  tx_en, tx_data, full, empty, level, overflow, sent_cnt, drop_cnt
    );
    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_status,
        output tx_en, tx_data, full, empty, level, overflow, sent_cnt, drop_cnt
    );
`else
    modport master (
        output wr_en, wr_data, clr_ovf, tx_status,
        input  tx_en, tx_data, full, empty, level, overflow
    );
    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_status,
        output tx_en, tx_data, full, empty, level, overflow
    );
`endif
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and a combinational head read.
module sync_fifo #(
    parameter int unsigned Width  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [ADDR_W:0]  level_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [Width-1:0]  mem_q [Depth];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, empty_q;

    // Caller guarantees push only when room exists (or a pop frees it) and pop only when non-empty.
    always_comb begin
        level_d = level_q;
        if (push_i && !pop_i) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (!push_i && pop_i) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            level_q <= level_d;
            full_q  <= (level_d == (ADDR_W + 1)'(Depth));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter one byte per tx_en strobe, paced by tx_status.
// Define UART_TXQ_STATS_EN to add saturating sent/dropped byte counters.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W       = AddrWDefault,
    parameter int unsigned BUSY_TIMEOUT = BusyTimeoutDefault
) (
    input logic            sysclk,
    input logic            reset,
    uart_tx_queue_if.slave bus
);

    localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    txq_state_e      state_q;
    logic            tx_en_q;
    logic [7:0]      tx_data_q;
    logic [TmoW-1:0] tmo_q;
    logic            ovf_q;

    logic            pop;
    logic            wr_accept;
    logic            wr_reject;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ADDR_W:0] fifo_level;

    assign pop       = (state_q == StLaunch);
    assign wr_accept = bus.wr_en && (!fifo_full || pop);
    assign wr_reject = bus.wr_en && !wr_accept;

    sync_fifo #(
        .Width  (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (reset),
        .push_i  (wr_accept),
        .pop_i   (pop),
        .din_i   (bus.wr_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= StIdle;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            tmo_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // tx_en/tx_data are loaded on entry so they are valid during LAUNCH.
                    if (!fifo_empty && bus.tx_status) begin
                        state_q   <= StLaunch;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= fifo_dout;
                    end
                end
                StLaunch: begin
                    tmo_q   <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (!bus.tx_status) begin
                        state_q <= StWaitDone;
                    end else if (tmo_q == TmoW'(BUSY_TIMEOUT - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StWaitDone: begin
                    if (bus.tx_status) state_q <= StIdle;
                end
            endcase

            if (wr_reject) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.level    = fifo_level;
    assign bus.overflow = ovf_q;

`ifdef UART_TXQ_STATS_EN
    logic [15:0] sent_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sent_cnt_q <= 16'h0000;
            drop_cnt_q <= 16'h0000;
        end else begin
            if (pop && (sent_cnt_q != 16'hFFFF))       sent_cnt_q <= sent_cnt_q + 16'd1;
            if (wr_reject && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.sent_cnt = sent_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected launch bytes are queued at write time and
// checked by a monitor on every tx_en; status outputs are checked directly by the stimulus.
module tb_uart_tx_queue;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.ADDR_W(4)) bus ();

    uart_tx_queue #(
        .ADDR_W       (4),
        .BUSY_TIMEOUT (16)
    ) dut (
        .sysclk (clk),
        .reset  (reset),
        .bus    (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];
    int         launch_cnt  = 0;
    int         last_launch = 0;
    int         prev_launch = 0;
    bit         hold_busy   = 1'b0;
    bit         stuck_idle  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model: goes busy the cycle after tx_en for 20 cycles.
    initial begin
        bus.tx_status = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_en === 1'b1 && !stuck_idle) begin
                @(posedge clk);
                #1 bus.tx_status = 1'b0;
                repeat (20) @(posedge clk);
                #1 bus.tx_status = 1'b1;
            end else begin
                bus.tx_status = !hold_busy;
            end
        end
    end

    // Monitor: every launch must match the next expected byte and occur with tx_status high.
    initial forever begin
        @(negedge clk);
        if (bus.tx_en === 1'b1) begin
            launch_cnt++;
            prev_launch = last_launch;
            last_launch = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_launch: got tx_data=0x%0h want no launch (cycle %0d)",
                         bus.tx_data, cyc);
            end else begin
                check("launch_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            check("status_at_launch", 32'(bus.tx_status), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit expect_sent);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (expect_sent) exp_q.push_back(b);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        repeat (30) step();
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        while (bus.tx_en !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({name, "_launch_seen"}, 32'(bus.tx_en), 32'd1);
    endtask

    initial begin
        int n0;
        int t0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);

        // Single byte: launch two cycles after the write
        t0 = cyc;
        n0 = launch_cnt;
        wr(8'h55, 1'b1);
        check("t1_empty_n1", 32'(bus.empty), 32'd0);
        check("t1_level_n1", 32'(bus.level), 32'd1);
        step();
        check("t1_tx_en_n2", 32'(bus.tx_en), 32'd1);
        check("t1_tx_data_n2", 32'(bus.tx_data), 32'h55);
        step();
        check("t1_level_n3", 32'(bus.level), 32'd0);
        check("t1_empty_n3", 32'(bus.empty), 32'd1);
        check("t1_tx_en_n3", 32'(bus.tx_en), 32'd0);
        check("t1_launch_cycle", 32'(last_launch - t0), 32'd2);
        drain("t1");
        check("t1_launches", 32'(launch_cnt - n0), 32'd1);

        // Burst of three bytes
        n0 = launch_cnt;
        wr(8'h01, 1'b1);
        wr(8'h02, 1'b1);
        wr(8'h03, 1'b1);
        drain("t2");
        check("t2_launches", 32'(launch_cnt - n0), 32'd3);

        // Overflow with transmitter held busy
        hold_busy = 1'b1;
        repeat (2) step();
        n0 = launch_cnt;
        for (int i = 0; i < 17; i++) wr(8'(8'h10 + i), i < 16);
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_level", 32'(bus.level), 32'd16);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        hold_busy = 1'b0;
        drain("t3");
        check("t3_launches", 32'(launch_cnt - n0), 32'd16);
        check("t3_empty", 32'(bus.empty), 32'd1);
        check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check("t3_ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full queue, write in the LAUNCH cycle is accepted
        hold_busy = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 16; i++) wr(8'(8'h30 + i), 1'b1);
        check("t4_full", 32'(bus.full), 32'd1);
        check("t4_level", 32'(bus.level), 32'd16);
        hold_busy = 1'b0;
        wait_launch("t4");
        wr(8'hAA, 1'b1);
        check("t4_level_after", 32'(bus.level), 32'd16);
        check("t4_overflow", 32'(bus.overflow), 32'd0);
        check("t4_full_after", 32'(bus.full), 32'd1);
        drain("t4");

        // Stuck transmitter: 16 WAIT_BUSY cycles give an 18-cycle launch spacing
        stuck_idle = 1'b1;
        n0 = launch_cnt;
        wr(8'h77, 1'b1);
        wr(8'h88, 1'b1);
        drain("t5");
        check("t5_launches", 32'(launch_cnt - n0), 32'd2);
        check("t5_spacing", 32'(last_launch - prev_launch), 32'd18);
        stuck_idle = 1'b0;
        repeat (5) step();
`ifdef UART_TXQ_STATS_EN
        check("stats_sent", 32'(bus.sent_cnt), 32'(launch_cnt));
        check("stats_drop", 32'(bus.drop_cnt), 32'd1);
`endif

        // Reset during WAIT_DONE with five bytes still queued
        hold_busy = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 6; i++) wr(8'(8'h61 + i), i == 0);
        hold_busy = 1'b0;
        wait_launch("t6");
        repeat (3) step();
        check("t6_level_pre", 32'(bus.level), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_level", 32'(bus.level), 32'd0);
        check("t6_empty", 32'(bus.empty), 32'd1);
        check("t6_tx_en", 32'(bus.tx_en), 32'd0);
        check("t6_tx_data", 32'(bus.tx_data), 32'h00);
        n0 = launch_cnt;
        repeat (60) step();
        check("t6_no_launch", 32'(launch_cnt - n0), 32'd0);
        wr(8'h99, 1'b1);
        drain("t6");
        check("t6_relaunch", 32'(launch_cnt - n0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
